// File: rtl/fpga_regs_bank_if.sv
// Byte-stream bus shared by the FPGA slave blocks.
// Carries master write bytes in, and per-channel readback and register state out.
interface fpga_regs_bank_if #(
    parameter int unsigned N_CH  = 9,
    parameter int unsigned BYTES = 2
);
    logic [7:0]              master_data;
    logic [N_CH-1:0]         valid_bus;
    logic [N_CH-1:0]         rdreq_bus;
    logic [N_CH-1:0]         have_msg_bus;
    logic [N_CH*8-1:0]       slave_data_bus;
    logic [N_CH*8-1:0]       len_bus;
    logic [N_CH*BYTES*8-1:0] regs_out;
    logic [N_CH-1:0]         upd_bus;

    modport master (
        output master_data, valid_bus, rdreq_bus,
        input  have_msg_bus, slave_data_bus, len_bus, regs_out, upd_bus
    );

    modport slave (
        input  master_data, valid_bus, rdreq_bus,
        output have_msg_bus, slave_data_bus, len_bus, regs_out, upd_bus
    );
endinterface

// File: rtl/fpga_regs_bank.sv
// Bank of multi-byte control registers written byte-serially (MSB first), with
// per-channel readback, optional auto-reverting pulse channels and partial-write timeout.
module fpga_regs_bank #(
    parameter int unsigned              N_CH       = 9,
    parameter int unsigned              BYTES      = 2,
    parameter logic [N_CH*BYTES*8-1:0]  RST_VAL    = '0,
    parameter logic [N_CH-1:0]          PULSE_MASK = '0,
    parameter int unsigned              PULSE_LEN  = 16,
    parameter int unsigned              TO_CYC     = 1024
) (
    input logic            clk,
    input logic            rst,
    fpga_regs_bank_if.slave bus
);
    localparam int unsigned W  = BYTES * 8;
    localparam int unsigned PW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned TW = $clog2(TO_CYC + 1);
    localparam int unsigned LW = $clog2(PULSE_LEN + 1);

    logic [PW-1:0]   wcnt_q   [N_CH];
    logic [PW-1:0]   wcnt_d   [N_CH];
    logic [W-1:0]    shadow_q [N_CH];
    logic [W-1:0]    shadow_d [N_CH];
    logic [W-1:0]    reg_q    [N_CH];
    logic [W-1:0]    reg_d    [N_CH];
    logic [TW-1:0]   idle_q   [N_CH];
    logic [TW-1:0]   idle_d   [N_CH];
    logic [LW-1:0]   pcnt_q   [N_CH];
    logic [LW-1:0]   pcnt_d   [N_CH];
    logic [7:0]      len_q    [N_CH];
    logic [7:0]      len_d    [N_CH];
    logic [PW-1:0]   rd_ptr_q [N_CH];
    logic [PW-1:0]   rd_ptr_d [N_CH];
    logic [N_CH-1:0] have_q, have_d;
    logic [N_CH-1:0] upd_q, upd_d;

    logic [N_CH-1:0] commit;
    logic [W-1:0]    shifted  [N_CH];
    logic [W-1:0]    rd_sel;

    // Shadow shifts one byte in per valid; on the last byte the shifted value is the full word.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            shifted[i] = (shadow_q[i] << 8) | W'(bus.master_data);
            commit[i]  = bus.valid_bus[i] && (wcnt_q[i] == PW'(BYTES - 1));
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wcnt_d[i]   = wcnt_q[i];
            shadow_d[i] = shadow_q[i];
            reg_d[i]    = reg_q[i];
            idle_d[i]   = idle_q[i];
            pcnt_d[i]   = pcnt_q[i];
            len_d[i]    = len_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            have_d[i]   = have_q[i];
            upd_d[i]    = commit[i];

            if (bus.valid_bus[i]) begin
                idle_d[i] = '0;
                if (commit[i]) begin
                    wcnt_d[i]   = '0;
                    shadow_d[i] = '0;
                end else begin
                    wcnt_d[i]   = wcnt_q[i] + 1'b1;
                    shadow_d[i] = shifted[i];
                end
            end else if (wcnt_q[i] != '0) begin
                if (idle_q[i] == TW'(TO_CYC - 1)) begin
                    wcnt_d[i]   = '0;
                    shadow_d[i] = '0;
                    idle_d[i]   = '0;
                end else begin
                    idle_d[i] = idle_q[i] + 1'b1;
                end
            end

            // A commit overrides both the pulse revert and any concurrent readback pop.
            if (commit[i]) begin
                reg_d[i]    = shifted[i];
                have_d[i]   = 1'b1;
                len_d[i]    = 8'(BYTES);
                rd_ptr_d[i] = '0;
                if (PULSE_MASK[i]) begin
                    pcnt_d[i] = LW'(PULSE_LEN);
                end
            end else begin
                if (pcnt_q[i] != '0) begin
                    pcnt_d[i] = pcnt_q[i] - 1'b1;
                    if (pcnt_q[i] == LW'(1)) begin
                        reg_d[i] = RST_VAL[i*W +: W];
                    end
                end
                if (bus.rdreq_bus[i] && have_q[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
                    len_d[i]    = len_q[i] - 8'd1;
                    if (len_q[i] == 8'd1) begin
                        have_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                wcnt_q[i]   <= '0;
                shadow_q[i] <= '0;
                reg_q[i]    <= RST_VAL[i*W +: W];
                idle_q[i]   <= '0;
                pcnt_q[i]   <= '0;
                len_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
            end
            have_q <= '0;
            upd_q  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                wcnt_q[i]   <= wcnt_d[i];
                shadow_q[i] <= shadow_d[i];
                reg_q[i]    <= reg_d[i];
                idle_q[i]   <= idle_d[i];
                pcnt_q[i]   <= pcnt_d[i];
                len_q[i]    <= len_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            have_q <= have_d;
            upd_q  <= upd_d;
        end
    end

    always_comb begin
        bus.regs_out       = '0;
        bus.slave_data_bus = '0;
        bus.len_bus        = '0;
        rd_sel             = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.regs_out[i*W +: W] = reg_q[i];
            bus.len_bus[i*8 +: 8]  = len_q[i];
            rd_sel = reg_q[i] >> (8 * (BYTES - 1 - int'(rd_ptr_q[i])));
            bus.slave_data_bus[i*8 +: 8] = have_q[i] ? rd_sel[7:0] : 8'h00;
        end
        bus.have_msg_bus = have_q;
        bus.upd_bus      = upd_q;
    end
endmodule

// File: tb/tb_fpga_regs_bank.sv
// Randomized bench for fpga_regs_bank against a queue/deadline reference model,
// preceded by directed scenarios with hand-computed expectations.
module tb_fpga_regs_bank;
    localparam int unsigned N_CH      = 9;
    localparam int unsigned BYTES     = 2;
    localparam int unsigned W         = BYTES * 8;
    localparam int unsigned PULSE_LEN = 4;
    localparam int unsigned TO_CYC    = 8;
    localparam logic [N_CH*W-1:0] RST_VAL    = (N_CH*W)'(16'h0001) << (5 * W);
    localparam logic [N_CH-1:0]   PULSE_MASK = 9'b0_0001_0000;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    fpga_regs_bank_if #(.N_CH(N_CH), .BYTES(BYTES)) bus ();

    fpga_regs_bank #(
        .N_CH      (N_CH),
        .BYTES     (BYTES),
        .RST_VAL   (RST_VAL),
        .PULSE_MASK(PULSE_MASK),
        .PULSE_LEN (PULSE_LEN),
        .TO_CYC    (TO_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: committed words, pending partial bytes, readback bytes left,
    // cycle of last byte and cycle at which a pulse reverts.
    logic [W-1:0] m_reg  [N_CH];
    logic [7:0]   m_part [N_CH][$];
    int           m_last [N_CH];
    int           m_left [N_CH];
    int           m_exp  [N_CH];
    logic [N_CH-1:0] m_upd;
    int           t;

    task automatic check(input string tag, input logic [N_CH*W-1:0] got,
                         input logic [N_CH*W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] d, input logic [N_CH-1:0] v,
                              input logic [N_CH-1:0] rq);
        logic [W-1:0] val;
        logic         did;
        for (int ch = 0; ch < N_CH; ch++) begin
            m_upd[ch] = 1'b0;
            did = 1'b0;
            if (r) begin
                m_reg[ch] = RST_VAL[ch*W +: W];
                m_part[ch].delete();
                m_left[ch] = 0;
                m_exp[ch]  = -1;
            end else begin
                if (v[ch]) begin
                    m_part[ch].push_back(d);
                    m_last[ch] = t;
                    if (m_part[ch].size() == BYTES) begin
                        val = '0;
                        for (int j = 0; j < BYTES; j++) val = (val << 8) | W'(m_part[ch][j]);
                        m_part[ch].delete();
                        m_reg[ch]  = val;
                        m_upd[ch]  = 1'b1;
                        m_left[ch] = BYTES;
                        m_exp[ch]  = PULSE_MASK[ch] ? t + PULSE_LEN : -1;
                        did = 1'b1;
                    end
                end else if (m_part[ch].size() > 0 && t - m_last[ch] >= TO_CYC) begin
                    m_part[ch].delete();
                end
                if (!did) begin
                    if (m_exp[ch] == t) begin
                        m_reg[ch] = RST_VAL[ch*W +: W];
                        m_exp[ch] = -1;
                    end
                    if (rq[ch] && m_left[ch] > 0) m_left[ch]--;
                end
            end
        end
        t++;
    endtask

    task automatic tick(input logic r, input logic [7:0] d, input logic [N_CH-1:0] v,
                        input logic [N_CH-1:0] rq);
        logic [N_CH*W-1:0] e_regs;
        logic [N_CH*8-1:0] e_len;
        logic [N_CH*8-1:0] e_sd;
        logic [N_CH-1:0]   e_have;
        rst = r;
        bus.master_data = d;
        bus.valid_bus   = v;
        bus.rdreq_bus   = rq;
        @(posedge clk);
        model_step(r, d, v, rq);
        #1;
        for (int ch = 0; ch < N_CH; ch++) begin
            e_regs[ch*W +: W] = m_reg[ch];
            e_have[ch]        = (m_left[ch] > 0);
            e_len[ch*8 +: 8]  = 8'(m_left[ch]);
            e_sd[ch*8 +: 8]   = (m_left[ch] > 0) ? m_reg[ch][(m_left[ch]-1)*8 +: 8] : 8'h00;
        end
        check("regs_out", bus.regs_out, e_regs);
        check("upd_bus", (N_CH*W)'(bus.upd_bus), (N_CH*W)'(m_upd));
        check("have_msg", (N_CH*W)'(bus.have_msg_bus), (N_CH*W)'(e_have));
        check("len_bus", (N_CH*W)'(bus.len_bus), (N_CH*W)'(e_len));
        check("slave_data", (N_CH*W)'(bus.slave_data_bus), (N_CH*W)'(e_sd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, '0, '0);
    endtask

    initial begin
        int dens;
        n_vec = 0;
        n_err = 0;
        t     = 0;
        for (int ch = 0; ch < N_CH; ch++) begin
            m_reg[ch]  = '0;
            m_last[ch] = 0;
            m_left[ch] = 0;
            m_exp[ch]  = -1;
        end
        m_upd = '0;

        // Reset value
        for (int i = 0; i < 3; i++) tick(1'b1, 8'h00, '0, '0);
        check("t1_regs", bus.regs_out, RST_VAL);
        check("t1_have", (N_CH*W)'(bus.have_msg_bus), '0);
        check("t1_len", (N_CH*W)'(bus.len_bus), '0);
        check("t1_upd", (N_CH*W)'(bus.upd_bus), '0);

        // Two-byte write and readback
        tick(1'b0, 8'hA5, 9'h001, '0);
        tick(1'b0, 8'h3C, 9'h001, '0);
        check("t2_upd", (N_CH*W)'(bus.upd_bus), (N_CH*W)'(9'h001));
        check("t2_ch0", (N_CH*W)'(bus.regs_out[15:0]), (N_CH*W)'(16'hA53C));
        check("t2_sd0", (N_CH*W)'(bus.slave_data_bus[7:0]), (N_CH*W)'(8'hA5));
        check("t2_len0", (N_CH*W)'(bus.len_bus[7:0]), (N_CH*W)'(8'd2));
        tick(1'b0, 8'h00, '0, 9'h001);
        check("t2_upd_off", (N_CH*W)'(bus.upd_bus), '0);
        check("t2_sd0b", (N_CH*W)'(bus.slave_data_bus[7:0]), (N_CH*W)'(8'h3C));
        tick(1'b0, 8'h00, '0, 9'h001);
        check("t2_have0", (N_CH*W)'(bus.have_msg_bus[0]), '0);
        tick(1'b0, 8'h00, '0, 9'h001);
        check("t2_len0_end", (N_CH*W)'(bus.len_bus[7:0]), '0);

        // Partial-write timeout
        tick(1'b0, 8'h11, 9'h004, '0);
        idle(TO_CYC);
        tick(1'b0, 8'h22, 9'h004, '0);
        tick(1'b0, 8'h33, 9'h004, '0);
        check("t3_ch2", (N_CH*W)'(bus.regs_out[47:32]), (N_CH*W)'(16'h2233));

        // Pulse channel, then rewrite during the pulse
        tick(1'b0, 8'h00, 9'h010, '0);
        tick(1'b0, 8'hFF, 9'h010, '0);
        idle(3);
        check("t4_hold", (N_CH*W)'(bus.regs_out[79:64]), (N_CH*W)'(16'h00FF));
        idle(1);
        check("t4_revert", (N_CH*W)'(bus.regs_out[79:64]), '0);
        tick(1'b0, 8'h00, 9'h010, '0);
        tick(1'b0, 8'hFF, 9'h010, '0);
        idle(1);
        tick(1'b0, 8'h00, 9'h010, '0);
        tick(1'b0, 8'hAA, 9'h010, '0);
        idle(3);
        check("t4_ext", (N_CH*W)'(bus.regs_out[79:64]), (N_CH*W)'(16'h00AA));
        idle(1);

        // Concurrent channels; commit racing a readback pop
        tick(1'b0, 8'h12, 9'h00A, '0);
        tick(1'b0, 8'h34, 9'h00A, '0);
        check("t5_ch1", (N_CH*W)'(bus.regs_out[31:16]), (N_CH*W)'(16'h1234));
        check("t5_ch3", (N_CH*W)'(bus.regs_out[63:48]), (N_CH*W)'(16'h1234));
        tick(1'b0, 8'h00, '0, 9'h002);
        tick(1'b0, 8'h12, 9'h002, '0);
        tick(1'b0, 8'h34, 9'h002, 9'h002);
        check("t5_len1", (N_CH*W)'(bus.len_bus[15:8]), (N_CH*W)'(8'd2));
        check("t5_sd1", (N_CH*W)'(bus.slave_data_bus[15:8]), (N_CH*W)'(8'h12));

        // Reset mid-write
        tick(1'b0, 8'hAA, 9'h040, '0);
        tick(1'b1, 8'h00, '0, '0);
        tick(1'b0, 8'hBE, 9'h040, '0);
        tick(1'b0, 8'hEF, 9'h040, '0);
        check("t6_ch6", (N_CH*W)'(bus.regs_out[111:96]), (N_CH*W)'(16'hBEEF));

        // Random traffic; density 0 blocks let partial writes time out
        dens = 2;
        for (int i = 0; i < 3000; i++) begin
            logic [N_CH-1:0] v;
            logic [N_CH-1:0] rq;
            if (i % 40 == 0) dens = $urandom_range(0, 4);
            for (int ch = 0; ch < N_CH; ch++) begin
                v[ch]  = ($urandom_range(0, 7) < dens);
                rq[ch] = ($urandom_range(0, 2) == 0);
            end
            tick(($urandom_range(0, 299) == 0), 8'($urandom), v, rq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
